// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Rate-coded spike transmitter. A WIDTH-bit rate is taken through a valid/ready
//   load handshake. Over a window of N = 2^WIDTH steps, exactly `rate` single-cycle
//   spikes are emitted on spike_out, spread evenly by a wrapping phase accumulator.
//
// Ports
//   clk        : system clock, all state updates on posedge
//   rst        : asynchronous active-high reset
//   load_valid : new rate presented on `rate`
//   rate       : spikes to emit in the next window, sampled on load acceptance
//   load_ready : encoder idle, a load will be accepted
//   stop       : abort the current window (ignored while idle)
//   spike_out  : registered spike, one cycle per spike
//   done       : one-cycle pulse when a window completes without abort
//   busy       : window in progress
module spike_rate_encoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] rate,
  output logic             load_ready,
  input  logic             stop,
  output logic             spike_out,
  output logic             done,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Step counter value just before the final step of a window (N-1).
  localparam logic [WIDTH:0] StepLast = {1'b0, {WIDTH{1'b1}}};

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   step_q;
  logic [WIDTH-1:0] rate_q;
  logic             spike_q;
  logic             done_q;

  // The carry out of the accumulator marks every crossing of a multiple of N in
  // k*rate, which is exactly the even-spread spike rule.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc_q} + {1'b0, rate_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      step_q  <= '0;
      rate_q  <= '0;
      spike_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          spike_q <= 1'b0;
          if (load_valid) begin
            rate_q  <= rate;
            acc_q   <= '0;
            step_q  <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (stop) begin
            // Abort beats a coincident final step: no spike, no done.
            state_q <= StIdle;
            acc_q   <= '0;
            step_q  <= '0;
            spike_q <= 1'b0;
          end else begin
            acc_q   <= sum[WIDTH-1:0];
            spike_q <= sum[WIDTH];
            step_q  <= step_q + 1'b1;
            if (step_q == StepLast) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign load_ready = (state_q == StIdle);
  assign busy       = (state_q == StRun);
  assign spike_out  = spike_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] rate = '0;
  logic         stop = 1'b0;
  logic         load_ready, spike_out, done, busy;

  spike_rate_encoder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .rate       (rate),
    .load_ready (load_ready),
    .stop       (stop),
    .spike_out  (spike_out),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic spike;
    logic done;
    logic busy;
    logic ready;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_fail = 0;
  int spike_cnt = 0;

  // Reference model state
  bit m_run = 1'b0;
  int m_rate = 0;
  int m_k = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compute the expected outputs for the cycle after the coming edge, queue
  // them, take the edge, then pop and compare.
  task automatic tick();
    exp_t e;
    e.spike = 1'b0;
    e.done  = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_k   = 0;
    end else if (!m_run) begin
      if (load_valid) begin
        m_run  = 1'b1;
        m_rate = int'(rate);
        m_k    = 0;
      end
    end else if (stop) begin
      m_run = 1'b0;
      m_k   = 0;
    end else begin
      m_k++;
      e.spike = ((m_k * m_rate) / N) > (((m_k - 1) * m_rate) / N);
      if (m_k == N) begin
        m_run  = 1'b0;
        e.done = 1'b1;
      end
    end
    e.busy  = m_run;
    e.ready = !m_run;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("spike_out", int'(spike_out), int'(e.spike));
    check("done", int'(done), int'(e.done));
    check("busy", int'(busy), int'(e.busy));
    check("load_ready", int'(load_ready), int'(e.ready));
    if (spike_out) spike_cnt++;
  endtask

  task automatic load(input int r);
    load_valid = 1'b1;
    rate = W'(r);
    tick();
    load_valid = 1'b0;
    spike_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spike"}, int'(spike_out), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ready"}, int'(load_ready), 1);
  endtask

  initial begin
    // Reset state
    #3;
    check_reset_outputs("por");
    load_valid = 1'b1;
    rate = 4'd7;
    tick();
    tick();
    load_valid = 1'b0;
    #2 rst = 1'b0;

    // rate 4: spikes at 4, 8, 12, 16; done with last spike
    load(4);
    repeat (N) tick();
    check("rate4_count", spike_cnt, 4);
    tick();

    // rate 5 and rate 15
    load(5);
    repeat (N) tick();
    check("rate5_count", spike_cnt, 5);
    tick();
    load(15);
    repeat (N) tick();
    check("rate15_count", spike_cnt, 15);

    // rate 0, then reload rate 8 at EN+1
    load(0);
    repeat (N) tick();
    check("rate0_count", spike_cnt, 0);
    load(8);
    repeat (N) tick();
    check("rate8_b2b_count", spike_cnt, 8);
    tick();

    // rate 8 aborted on the edge of step 6
    load(8);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_count", spike_cnt, 2);
    tick();

    // stop together with load_valid while idle: load taken
    stop = 1'b1;
    load(3);
    stop = 1'b0;
    check("stop_load_busy", int'(busy), 1);
    repeat (N) tick();
    check("stop_load_count", spike_cnt, 3);

    // stop coincident with step N: abort wins
    load(4);
    repeat (N - 1) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_last_count", spike_cnt, 3);
    tick();

    // load attempt and rate change mid-window are ignored
    load(6);
    repeat (3) tick();
    load_valid = 1'b1;
    rate = 4'd1;
    tick();
    load_valid = 1'b0;
    repeat (N - 4) tick();
    check("midload_count", spike_cnt, 6);
    tick();

    // async reset at step 9 of a rate 12 window
    load(12);
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("rst_noload_busy", int'(busy), 0);
    #2 rst = 1'b0;
    load(3);
    repeat (N) tick();
    check("post_rst_count", spike_cnt, 3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
